// File: rtl/instruction_encoder.sv
// ---------------------------------------------------------------------------
// instruction_encoder
//
// Producer-side counterpart of the instruction decoder. Field-level requests
// are packed into 32-bit big-endian instruction words (bit 0 = MSB), pushed
// into a small FIFO and issued to the decoder with a valid/ready handshake.
//
// Optional feature macro: INSTRUCTION_ENCODER_NOP_PAD_EN
//   defined   : an empty FIFO presents a NOP pad word with instr_valid=1;
//               handshakes on pad words are counted in nop_count.
//   undefined : instr_valid=0 when empty, nop_count tied to 0.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   req_valid      in   request present
//   req_ready      out  request accepted when req_valid && req_ready
//   req_kind       in   0=ALU 1=LD 2=SD 3=BEZ 4=BNEZ 5..7=illegal
//   req_rd/ra/rb   in   register fields
//   req_ppp        in   participation field
//   req_ww         in   width field
//   req_alu_op     in   ALU/SFU function
//   req_imm        in   immediate / address
//   flush          in   synchronous FIFO clear (priority over push/pop)
//   instruction    out  FIFO head word (NOP word when empty)
//   instr_valid    out  instruction valid
//   instr_ready    in   consumer takes the word on valid && ready
//   fifo_count     out  current occupancy
//   issued_count   out  real words handed off (saturating)
//   illegal_count  out  illegal requests encoded (saturating)
//   nop_count      out  pad words handed off (saturating)
// ---------------------------------------------------------------------------
module instruction_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [0:2]             req_kind,
    input  logic [0:4]             req_rd,
    input  logic [0:4]             req_ra,
    input  logic [0:4]             req_rb,
    input  logic [0:2]             req_ppp,
    input  logic [0:1]             req_ww,
    input  logic [0:5]             req_alu_op,
    input  logic [0:15]            req_imm,
    input  logic                   flush,
    output logic [0:31]            instruction,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [0:$clog2(DEPTH)] fifo_count,
    output logic [0:CNT_W-1]       issued_count,
    output logic [0:CNT_W-1]       illegal_count,
    output logic [0:CNT_W-1]       nop_count
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [0:31] NOP_WORD = 32'hF000_0000;
    localparam logic [0:5]  OP_ALU   = 6'b101010;
    localparam logic [0:5]  OP_LD    = 6'b100000;
    localparam logic [0:5]  OP_SD    = 6'b100001;
    localparam logic [0:5]  OP_BEZ   = 6'b100010;
    localparam logic [0:5]  OP_BNEZ  = 6'b100011;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Encode stage (combinational on the request)
    // ------------------------------------------------------------------
    logic        rb_zero;
    logic [0:4]  rb_eff;
    logic [0:31] enc_word;
    logic        enc_illegal;

    // Unary/immediate-style ALU functions have no rB operand; the field is
    // forced to zero so the decoder never sees a stale register number.
    assign rb_zero = (req_alu_op == 6'b000100) || (req_alu_op == 6'b000101) ||
                     (req_alu_op == 6'b001101) || req_alu_op[1];
    assign rb_eff  = rb_zero ? 5'd0 : req_rb;

    always_comb begin
        enc_word    = NOP_WORD;
        enc_illegal = 1'b0;
        case (req_kind)
            3'd0:    enc_word = {OP_ALU, req_rd, req_ra, rb_eff, req_ppp, req_ww, req_alu_op};
            3'd1:    enc_word = {OP_LD,   req_rd, 5'd0, req_imm};
            3'd2:    enc_word = {OP_SD,   req_rd, 5'd0, req_imm};
            3'd3:    enc_word = {OP_BEZ,  req_rd, 5'd0, req_imm};
            3'd4:    enc_word = {OP_BNEZ, req_rd, 5'd0, req_imm};
            default: enc_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [0:31]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] illegal_q, illegal_d;
    logic             active_q;
    logic             empty, full, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W+1)'(DEPTH));

    // active_q holds req_ready low for the first cycle after reset release.
    assign req_ready   = active_q && !full;
    assign instruction = empty ? NOP_WORD : mem_q[rd_ptr_q];
    assign fifo_count  = count_q;

`ifdef INSTRUCTION_ENCODER_NOP_PAD_EN
    logic             pad_take;
    logic [CNT_W-1:0] nop_q, nop_d;

    assign instr_valid = active_q;
    assign pad_take    = instr_valid && instr_ready && empty && !flush;
    assign nop_d       = pad_take ? sat_inc(nop_q) : nop_q;
    assign nop_count   = nop_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) nop_q <= '0;
        else        nop_q <= nop_d;
    end
`else
    assign instr_valid = !empty;
    assign nop_count   = '0;
`endif

    assign push = req_valid && req_ready && !flush;
    assign pop  = instr_valid && instr_ready && !empty && !flush;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        issued_d  = issued_q;
        illegal_d = illegal_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (enc_illegal) illegal_d = sat_inc(illegal_q);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                issued_d = sat_inc(issued_q);
            end
            if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
            else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            issued_q  <= '0;
            illegal_q <= '0;
            active_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            issued_q  <= issued_d;
            illegal_q <= illegal_d;
            active_q  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Storage stage (data only, no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= enc_word;
    end

    assign issued_count  = issued_q;
    assign illegal_count = illegal_q;

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
`ifdef INSTRUCTION_ENCODER_NOP_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [0:2]  req_kind = '0;
    logic [0:4]  req_rd = '0, req_ra = '0, req_rb = '0;
    logic [0:2]  req_ppp = '0;
    logic [0:1]  req_ww = '0;
    logic [0:5]  req_alu_op = '0;
    logic [0:15] req_imm = '0;
    logic        flush = 1'b0;
    logic [0:31] instruction;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [0:$clog2(DEPTH)] fifo_count;
    logic [0:CNT_W-1] issued_count, illegal_count, nop_count;

    instruction_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_rd(req_rd), .req_ra(req_ra), .req_rb(req_rb),
        .req_ppp(req_ppp), .req_ww(req_ww), .req_alu_op(req_alu_op), .req_imm(req_imm),
        .flush(flush), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fifo_count(fifo_count), .issued_count(issued_count),
        .illegal_count(illegal_count), .nop_count(nop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mq[$];
    int m_iss = 0, m_ill = 0, m_nop = 0;
    bit m_active = 1'b0;
    bit m_rdy, m_has, m_vld;
    int cnt_max = (1 << CNT_W) - 1;

    function automatic logic [31:0] model_word(int kind, int rd, int ra, int rb, int ppp,
                                               int ww, int op, int imm);
        logic [31:0] w;
        int b;
        if (kind == 0) begin
            b = rb;
            if (op == 4 || op == 5 || op == 13 || ((op >> 4) & 1) == 1) b = 0;
            w = (32'(42) << 26) | (32'(rd) << 21) | (32'(ra) << 16) | (32'(b) << 11) |
                (32'(ppp) << 8) | (32'(ww) << 6) | 32'(op);
        end else if (kind <= 4) begin
            w = (32'(31 + kind) << 26) | (32'(rd) << 21) | 32'(imm);
        end else begin
            w = 32'hF000_0000;
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_rdy = m_active && (mq.size() < DEPTH);
            m_has = mq.size() > 0;
            m_vld = m_active && (m_has || PAD);
            if (flush) begin
                mq.delete();
            end else begin
                if (m_vld && instr_ready) begin
                    if (m_has) begin
                        void'(mq.pop_front());
                        if (m_iss < cnt_max) m_iss++;
                    end else if (m_nop < cnt_max) m_nop++;
                end
                if (req_valid && m_rdy) begin
                    mq.push_back(model_word(int'(req_kind), int'(req_rd), int'(req_ra),
                                            int'(req_rb), int'(req_ppp), int'(req_ww),
                                            int'(req_alu_op), int'(req_imm)));
                    if (int'(req_kind) > 4 && m_ill < cnt_max) m_ill++;
                end
            end
            m_active = 1'b1;
        end
    end

    always @(negedge reset) begin
        mq.delete();
        m_iss = 0;
        m_ill = 0;
        m_nop = 0;
        m_active = 1'b0;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("instr_valid", 32'(instr_valid), 32'(m_active && (mq.size() > 0 || PAD)));
        chk("instruction", instruction, (mq.size() > 0) ? mq[0] : 32'hF000_0000);
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("req_ready", 32'(req_ready), 32'(m_active && mq.size() < DEPTH));
        chk("issued_count", 32'(issued_count), 32'(m_iss));
        chk("illegal_count", 32'(illegal_count), 32'(m_ill));
        chk("nop_count", 32'(nop_count), 32'(m_nop));
    end

    // ---------------- stimulus ----------------
    task automatic set_req(input int kind, input int rd, input int ra, input int rb,
                           input int ppp, input int ww, input int op, input int imm);
        req_kind   = 3'(kind);
        req_rd     = 5'(rd);
        req_ra     = 5'(ra);
        req_rb     = 5'(rb);
        req_ppp    = 3'(ppp);
        req_ww     = 2'(ww);
        req_alu_op = 6'(op);
        req_imm    = 16'(imm);
        req_valid  = 1'b1;
    endtask

    task automatic push_pop_one(input string name, input logic [31:0] exp_word);
        @(negedge clk);
        req_valid = 1'b0;
        chk({name, "_word"}, instruction, exp_word);
        chk({name, "_valid"}, 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_instruction", instruction, 32'hF000_0000);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);

        // ALU add
        set_req(0, 3, 1, 2, 0, 2, 6'b000001, 0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("alu_add_word", instruction, 32'hA861_1081);
        chk("model_alu_add", model_word(0, 3, 1, 2, 0, 2, 1, 0), 32'hA861_1081);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("alu_add_issued", 32'(issued_count), 32'd1);

        // MOV with rB suppression, LD, illegal
        set_req(0, 3, 1, 7, 0, 2, 6'b000101, 0);
        push_pop_one("mov", 32'hA861_0085);
        set_req(1, 5, 9, 0, 0, 0, 0, 16'h0040);
        push_pop_one("ld", 32'h80A0_0040);
        set_req(6, 4, 4, 4, 1, 1, 3, 16'h1234);
        @(negedge clk);
        req_valid = 1'b0;
        chk("illegal_word", instruction, 32'hF000_0000);
        chk("illegal_valid", 32'(instr_valid), 32'd1);
        chk("illegal_count", 32'(illegal_count), 32'd1);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;

        // full / backpressure with five requests
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            case (i)
                0: set_req(0, 10, 11, 9, 5, 1, 6'b010000, 0);
                1: set_req(2, 7, 3, 0, 0, 0, 0, 16'hBEEF);
                2: set_req(3, 1, 0, 0, 0, 0, 0, 16'h0004);
                3: set_req(4, 31, 31, 0, 0, 0, 0, 16'hFFFF);
                default: set_req(0, 2, 4, 6, 7, 3, 6'b001101, 0);
            endcase
        end
        chk("full_req_ready", 32'(req_ready), 32'd0);
        chk("full_count", 32'(fifo_count), 32'd4);
        repeat (2) @(negedge clk);
        instr_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        chk("fifth_ready_seen", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (fifo_count == 0) break;
            @(negedge clk);
        end
        instr_ready = 1'b0;
        chk("drain_count", 32'(fifo_count), 32'd0);

        // push + pop with count = 2
        @(negedge clk);
        set_req(0, 1, 2, 3, 0, 0, 6'b000010, 0);
        @(negedge clk);
        set_req(1, 8, 0, 0, 0, 0, 0, 16'h0100);
        @(negedge clk);
        set_req(2, 9, 0, 0, 0, 0, 0, 16'h0200);
        instr_ready = 1'b1;
        @(negedge clk);
        chk("pushpop_count", 32'(fifo_count), 32'd2);
        req_valid = 1'b0;
        instr_ready = 1'b0;

        // flush + request with count = 3
        set_req(3, 12, 0, 0, 0, 0, 0, 16'h0300);
        @(negedge clk);
        set_req(7, 1, 1, 1, 1, 1, 1, 1);
        flush = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        instr_ready = 1'b0;
        chk("flush_count", 32'(fifo_count), 32'd0);
        chk("flush_issued", 32'(issued_count), 32'd10);
        chk("flush_illegal", 32'(illegal_count), 32'd1);

        // asynchronous reset with two entries held
        set_req(1, 2, 0, 0, 0, 0, 0, 16'h0010);
        @(negedge clk);
        set_req(2, 3, 0, 0, 0, 0, 0, 16'h0020);
        @(negedge clk);
        req_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        chk("arst_issued", 32'(issued_count), 32'd0);
        chk("arst_instruction", instruction, 32'hF000_0000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // three cycles with empty FIFO and consumer ready
        instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        instr_ready = 1'b0;
`ifdef INSTRUCTION_ENCODER_NOP_PAD_EN
        chk("pad_nop_count", 32'(nop_count), 32'd3);
`else
        chk("pad_nop_count", 32'(nop_count), 32'd0);
`endif
        chk("pad_issued", 32'(issued_count), 32'd0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Producer-side counterpart of the instruction decoder.
- Accepts field-level instruction requests and packs each into a 32-bit word using the same big-endian bit layout and opcodes the decoder expects.
- Buffers words in a small FIFO and issues them with a valid/ready handshake.
- Sits between the program sequencer/test driver and the decoder's instruction input.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_kind  in  [0:2]  0=ALU, 1=LD, 2=SD, 3=BEZ, 4=BNEZ, 5-7=illegal.
- req_rd  in  [0:4]  destination register.
- req_ra  in  [0:4]  source A.
- req_rb  in  [0:4]  source B.
- req_ppp  in  [0:2]  participation field.
- req_ww  in  [0:1]  width field.
- req_alu_op  in  [0:5]  ALU/SFU function.
- req_imm  in  [0:15]  immediate/address.
- flush  in  1  synchronous FIFO clear.
- instruction  out  [0:31]  FIFO head word.
- instr_valid  out  1  instruction is valid.
- instr_ready  in  1  consumer takes the word when instr_valid && instr_ready.
- fifo_count  out  [0:$clog2(DEPTH)]  current occupancy.
- issued_count  out  [0:CNT_W-1]  words handed off.
- illegal_count  out  [0:CNT_W-1]  illegal requests encoded.
- nop_count  out  [0:CNT_W-1]  padded NOPs issued; tied 0 without the optional feature.

Behaviour:
- Field positions in the word:
  - opcode [0:5]
  - rD [6:10]
  - rA [11:15]
  - rB [16:20]
  - ppp [21:23]
  - ww [24:25]
  - alu_op [26:31]
  - imm [16:31]
- Opcodes: ALU 101010, LD 100000, SD 100001, BEZ 100010, BNEZ 100011, NOP 111100.
- ALU encoding:
  - opcode, rD, rA, ppp, ww and alu_op are taken from the request.
  - rB field = 0 when alu_op is 000100, 000101 or 001101, or when alu_op[1]=1; otherwise rB = req_rb.
- LD/SD/BEZ/BNEZ encoding: opcode, rD=req_rd, rA field=0, imm=req_imm. req_ra, req_rb, req_ppp, req_ww and req_alu_op are ignored.
- Illegal kind (5-7): encodes NOP word 0xF0000000 and increments illegal_count.
- Encoding is combinational on the request; the word is written into the FIFO on the accepting edge.
- req_ready = !full. A push is refused when full, even if a pop occurs in the same cycle.
- Latency: a request accepted at edge N appears on instruction with instr_valid=1 after edge N. There is no empty-FIFO bypass.
- Pop on instr_valid && instr_ready; issued_count increments.
- Push and pop in the same cycle (not full, not empty): both happen and fifo_count is unchanged.
- instr_valid = !empty.
- When empty, instruction = 0xF0000000.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH; fifo_count is maintained separately.
- flush has priority over push and pop in the same cycle:
  - The FIFO empties after the edge.
  - A request presented that cycle is dropped and counts nothing.
  - The statistics counters retain their values.
- Counters saturate at all-ones.
- Reset (asynchronous, active low), asserted at any time including mid-transfer:
  - pointers=0, fifo_count=0, all counters=0.
  - instr_valid=0, req_ready=0 while reset is low.
  - instruction=0xF0000000.
  - FIFO contents are discarded.
- After reset deasserts, req_ready=1 on the next cycle.

Optional Feature:
- Macro: INSTRUCTION_ENCODER_NOP_PAD_EN.
- Defined: when the FIFO is empty, instr_valid=1 with instruction=0xF0000000 (bubble padding).
  - A handshake on a pad word increments nop_count, not issued_count.
  - Real entries always take precedence over padding.
- Undefined: instr_valid=0 when empty and nop_count is tied to 0.

Test Plan:
- ALU add: kind=0, rd=3, ra=1, rb=2, ppp=0, ww=2, op=000001 -> instruction=0xA8611081 one cycle after accept; issued_count=1 after handshake.
- MOV with rB suppression: kind=0, rd=3, ra=1, rb=7, ww=2, op=000101 -> 0xA8610085 (rB field 0).
- LD: kind=1, rd=5, ra=9, imm=0x0040 -> 0x80A00040 (ra ignored). Illegal kind=6 -> 0xF0000000 and illegal_count=1.
- Full/backpressure: DEPTH=4, instr_ready=0, push 5 requests -> req_ready=0 after the 4th, fifo_count=4, 5th held. Raise instr_ready -> 4 words emerge in order, then the 5th is accepted.
- Simultaneous events:
  - Push+pop with count=2 -> count stays 2.
  - flush + req_valid with count=3 -> count=0, request dropped, counters unchanged.
- Reset mid-operation: assert reset low asynchronously with 2 entries -> instr_valid=0 and counts=0 before the next clk edge. With NOP_PAD_EN defined, empty + instr_ready=1 for 3 cycles -> 3 pad words, nop_count=3.
